// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller: write/read addresses, count, registered full/empty flags and a 3-state FSM.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl #(
   parameter int AW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wr,
   input  logic          i_rd,
   output logic          o_wr_en,
   output logic          o_rd_en,
   output logic [AW-1:0] o_waddr,
   output logic [AW-1:0] o_raddr,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic [1:0]    o_state
`ifdef FIFO_CTRL_ERR_EN
   ,
   input  logic          i_clr_err,
   output logic          o_ovf,
   output logic          o_udf
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_MID   = 2'b01,
      S_FULL  = 2'b10
   } state_t;

   localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);
   localparam logic [AW:0] CNT_LAST    = {1'b0, {AW{1'b1}}};
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   state_t state;
   logic   wr_only;
   logic   rd_only;

   // Request/accept: i_wr/i_rd are requests held by the source; o_wr_en/o_rd_en
   // say the request is accepted this cycle, and only accepted requests change state.
   assign o_rd_en = i_rd & ~o_empty;
   assign o_wr_en = i_wr & (~o_full | o_rd_en);
   assign wr_only = o_wr_en & ~o_rd_en;
   assign rd_only = o_rd_en & ~o_wr_en;
   assign o_state = state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_waddr <= '0;
         o_raddr <= '0;
         o_count <= '0;
      end else begin
         if (o_wr_en) o_waddr <= o_waddr + PTR_ONE;
         if (o_rd_en) o_raddr <= o_raddr + PTR_ONE;
         if (wr_only)      o_count <= o_count + CNT_ONE;
         else if (rd_only) o_count <= o_count - CNT_ONE;
      end
   end

   // Flags are registered alongside the state so they always agree with it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= S_EMPTY;
         o_empty <= 1'b1;
         o_full  <= 1'b0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (wr_only) begin
                  state   <= S_MID;
                  o_empty <= 1'b0;
               end
            end
            S_MID: begin
               if (wr_only && o_count == CNT_LAST) begin
                  state  <= S_FULL;
                  o_full <= 1'b1;
               end else if (rd_only && o_count == CNT_ONE) begin
                  state   <= S_EMPTY;
                  o_empty <= 1'b1;
               end
            end
            S_FULL: begin
               if (rd_only) begin
                  state  <= S_MID;
                  o_full <= 1'b0;
               end
            end
            default: begin
               state   <= S_EMPTY;
               o_empty <= 1'b1;
               o_full  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_CTRL_ERR_EN
   // Clear wins over a same-cycle set.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_ovf <= 1'b0;
         o_udf <= 1'b0;
      end else if (i_clr_err) begin
         o_ovf <= 1'b0;
         o_udf <= 1'b0;
      end else begin
         if (i_wr && o_full && !o_rd_en) o_ovf <= 1'b1;
         if (i_rd && o_empty)            o_udf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl at AW=2 (depth 4): fill, overflow attempt, write+read while full,
// drain, write+read while empty, wrapping pairs and an asynchronous reset between edges.
module tb_fifo_ctrl;

   localparam int AW = 2;

   logic          i_clk;
   logic          i_rst;
   logic          i_wr;
   logic          i_rd;
   logic          o_wr_en;
   logic          o_rd_en;
   logic [AW-1:0] o_waddr;
   logic [AW-1:0] o_raddr;
   logic [AW:0]   o_count;
   logic          o_full;
   logic          o_empty;
   logic [1:0]    o_state;
`ifdef FIFO_CTRL_ERR_EN
   logic          i_clr_err;
   logic          o_ovf;
   logic          o_udf;
`endif

   int checks;
   int errors;

   fifo_ctrl #(.AW(AW)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr      (i_wr),
      .i_rd      (i_rd),
      .o_wr_en   (o_wr_en),
      .o_rd_en   (o_rd_en),
      .o_waddr   (o_waddr),
      .o_raddr   (o_raddr),
      .o_count   (o_count),
      .o_full    (o_full),
      .o_empty   (o_empty),
      .o_state   (o_state)
`ifdef FIFO_CTRL_ERR_EN
      ,
      .i_clr_err (i_clr_err),
      .o_ovf     (o_ovf),
      .o_udf     (o_udf)
`endif
   );

   // clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_regs(input string tag, input int cnt, input int wa, input int ra, input int st);
      check_val({tag, "_count"}, 32'(o_count), 32'(cnt));
      check_val({tag, "_waddr"}, 32'(o_waddr), 32'(wa));
      check_val({tag, "_raddr"}, 32'(o_raddr), 32'(ra));
      check_val({tag, "_state"}, 32'(o_state), 32'(st));
      check_val({tag, "_full"},  32'(o_full),  32'(st == 2));
      check_val({tag, "_empty"}, 32'(o_empty), 32'(st == 0));
   endtask

   // Called 1 ns after a rising edge: apply requests, check accept, cross one edge.
   task automatic step(input string tag, input logic wr, input logic rd,
                       input logic exp_wen, input logic exp_ren);
      i_wr = wr;
      i_rd = rd;
      #1;
      check_val({tag, "_wen"}, 32'(o_wr_en), 32'(exp_wen));
      check_val({tag, "_ren"}, 32'(o_rd_en), 32'(exp_ren));
      @(posedge i_clk);
      #1;
      i_wr = 1'b0;
      i_rd = 1'b0;
      #1;
   endtask

   initial begin
      int wa;
      int ra;
      checks = 0;
      errors = 0;
      i_rst  = 1'b1;
      i_wr   = 1'b0;
      i_rd   = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
      i_clr_err = 1'b0;
`endif
      #12;
      expect_regs("reset", 0, 0, 0, 0);
      #11;
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;

      // read on empty is rejected
      step("rd_empty", 1'b0, 1'b1, 1'b0, 1'b0);
      expect_regs("rd_empty", 0, 0, 0, 0);
`ifdef FIFO_CTRL_ERR_EN
      check_val("udf_set", 32'(o_udf), 32'd1);
      i_clr_err = 1'b1;
      @(posedge i_clk);
      #1;
      i_clr_err = 1'b0;
      check_val("udf_clr", 32'(o_udf), 32'd0);
`endif

      // fill
      step("w1", 1'b1, 1'b0, 1'b1, 1'b0);
      expect_regs("w1", 1, 1, 0, 1);
      step("w2", 1'b1, 1'b0, 1'b1, 1'b0);
      expect_regs("w2", 2, 2, 0, 1);
      step("w3", 1'b1, 1'b0, 1'b1, 1'b0);
      expect_regs("w3", 3, 3, 0, 1);
      step("w4", 1'b1, 1'b0, 1'b1, 1'b0);
      expect_regs("w4", 4, 0, 0, 2);

      // write while full is rejected
      step("ovf", 1'b1, 1'b0, 1'b0, 1'b0);
      expect_regs("ovf", 4, 0, 0, 2);
`ifdef FIFO_CTRL_ERR_EN
      check_val("ovf_set", 32'(o_ovf), 32'd1);
      @(posedge i_clk);
      #1;
      check_val("ovf_hold", 32'(o_ovf), 32'd1);
      i_clr_err = 1'b1;
      @(posedge i_clk);
      #1;
      i_clr_err = 1'b0;
      check_val("ovf_clr", 32'(o_ovf), 32'd0);
`endif

      // write+read while full
      step("wr_full", 1'b1, 1'b1, 1'b1, 1'b1);
      expect_regs("wr_full", 4, 1, 1, 2);

      // drain
      step("r1", 1'b0, 1'b1, 1'b0, 1'b1);
      expect_regs("r1", 3, 1, 2, 1);
      step("r2", 1'b0, 1'b1, 1'b0, 1'b1);
      expect_regs("r2", 2, 1, 3, 1);
      step("r3", 1'b0, 1'b1, 1'b0, 1'b1);
      expect_regs("r3", 1, 1, 0, 1);
      step("r4", 1'b0, 1'b1, 1'b0, 1'b1);
      expect_regs("r4", 0, 1, 1, 0);

      // write+read while empty: only the write is accepted
      step("wr_empty", 1'b1, 1'b1, 1'b1, 1'b0);
      expect_regs("wr_empty", 1, 2, 1, 1);
`ifdef FIFO_CTRL_ERR_EN
      check_val("udf_wr_empty", 32'(o_udf), 32'd1);
      i_clr_err = 1'b1;
      @(posedge i_clk);
      #1;
      i_clr_err = 1'b0;
`endif

      // 10 interleaved write/read pairs at count 1
      wa = 2;
      ra = 1;
      for (int i = 0; i < 10; i++) begin
         step($sformatf("pair%0d", i), 1'b1, 1'b1, 1'b1, 1'b1);
         wa = (wa + 1) % 4;
         ra = (ra + 1) % 4;
         expect_regs($sformatf("pair%0d", i), 1, wa, ra, 1);
      end

      // reach count 2, then reset asynchronously between edges
      step("w_pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
      expect_regs("w_pre_rst", 2, 1, 3, 1);
      i_rst = 1'b1;
      #1;
      expect_regs("rst_async", 0, 0, 0, 0);
      i_wr = 1'b1;
      i_rd = 1'b1;
      #1;
      check_val("rst_wen", 32'(o_wr_en), 32'd1);
      check_val("rst_ren", 32'(o_rd_en), 32'd0);
      @(posedge i_clk);
      #1;
      expect_regs("rst_hold", 0, 0, 0, 0);
      i_wr  = 1'b0;
      i_rd  = 1'b0;
      i_rst = 1'b0;
      #1;
      step("w_post_rst", 1'b1, 1'b0, 1'b1, 1'b0);
      expect_regs("w_post_rst", 1, 1, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
